// File: rtl/prog_loader.sv
// Program loader / run controller for the 4-bit datapath: streams instruction words into the
// instruction RAM, arms the PC with a start address and gates execution until a halt or budget expiry.
module prog_loader #(
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = 4,
    parameter int INS_W      = 9,
    parameter int MAX_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INS_W-1:0]  IN_INS,
    input  logic              in_last,
    input  logic              start,
    input  logic [ADDR_W-1:0] START_ADDR,
    input  logic [ADDR_W-1:0] HALT_ADDR,
    input  logic [ADDR_W-1:0] PC_CURR,
    output logic              wr_en,
    output logic [ADDR_W-1:0] WR_ADDR,
    output logic [INS_W-1:0]  WR_DATA,
    output logic              set_pc,
    output logic [ADDR_W-1:0] PC_INIT,
    output logic              run,
    output logic              done,
    output logic              timeout,
    output logic              load_err,
    output logic [7:0]        CYCLES
);

    localparam int PTR_W = $clog2(DEPTH + 1);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_ARM  = 3'd2;
    localparam logic [2:0] ST_RUN  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    localparam logic [PTR_W-1:0] PTR_FULL = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [7:0]       CYC_LAST = 8'(MAX_CYCLES - 1);

    logic [2:0]        state_r;
    logic [2:0]        state_next_s;
    logic [PTR_W-1:0]  wptr_r;
    logic [PTR_W-1:0]  wptr_next_s;

    logic              in_ready_r;
    logic              wr_en_r;
    logic [ADDR_W-1:0] wr_addr_r;
    logic [INS_W-1:0]  wr_data_r;
    logic              set_pc_r;
    logic [ADDR_W-1:0] pc_init_r;
    logic              done_r;
    logic              timeout_r;
    logic              load_err_r;
    logic [7:0]        cycles_r;

    logic              xfer_s;
    logic              fresh_s;
    logic              space_s;
    logic              write_s;
    logic              run_s;
    logic              budget_hit_s;
    logic              arm_req_s;

    // Handshake, write qualification and run/halt decode.
    always_comb begin
        fresh_s      = (state_r == ST_IDLE) || (state_r == ST_DONE);
        xfer_s       = in_valid & in_ready_r;
        // A fresh program always restarts at word 0, so there is always room.
        space_s      = fresh_s || (wptr_r != PTR_FULL);
        write_s      = xfer_s & space_s;
        run_s        = (state_r == ST_RUN) && (PC_CURR != HALT_ADDR);
        budget_hit_s = run_s && (cycles_r == CYC_LAST);
        arm_req_s    = fresh_s && start && !xfer_s;
    end

    // Next-state and write-pointer decode.
    always_comb begin
        state_next_s = state_r;
        wptr_next_s  = wptr_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (xfer_s) begin
                    state_next_s = in_last ? ST_IDLE : ST_LOAD;
                    wptr_next_s  = in_last ? {PTR_W{1'b0}} : PTR_ONE;
                end else if (start) begin
                    state_next_s = ST_ARM;
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_LOAD: begin
                if (xfer_s && in_last) begin
                    state_next_s = ST_IDLE;
                    wptr_next_s  = {PTR_W{1'b0}};
                end else if (xfer_s && space_s) begin
                    wptr_next_s  = wptr_r + PTR_ONE;
                end else begin
                    wptr_next_s  = wptr_r;
                end
            end
            ST_ARM: begin
                state_next_s = ST_RUN;
            end
            ST_RUN: begin
                if (!run_s || budget_hit_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                wptr_next_s  = {PTR_W{1'b0}};
            end
        endcase
    end

    // State and write-pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            wptr_r  <= {PTR_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            wptr_r  <= wptr_next_s;
        end
    end

    // Registered RAM write port, one cycle behind the accepted transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en_r   <= 1'b0;
            wr_addr_r <= {ADDR_W{1'b0}};
            wr_data_r <= {INS_W{1'b0}};
        end else begin
            wr_en_r <= write_s;
            if (write_s) begin
                wr_addr_r <= fresh_s ? {ADDR_W{1'b0}} : wptr_r[ADDR_W-1:0];
                wr_data_r <= IN_INS;
            end
        end
    end

    // Control outputs registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_r <= 1'b1;
            set_pc_r   <= 1'b1;
            done_r     <= 1'b0;
            pc_init_r  <= {ADDR_W{1'b0}};
        end else begin
            in_ready_r <= (state_next_s == ST_IDLE) || (state_next_s == ST_LOAD) ||
                          (state_next_s == ST_DONE);
            set_pc_r   <= (state_next_s != ST_RUN);
            done_r     <= (state_next_s == ST_DONE);
            // Parked at the halt address after a run so the PC stays frozen there.
            if (arm_req_s) begin
                pc_init_r <= START_ADDR;
            end else if (state_next_s == ST_DONE) begin
                pc_init_r <= HALT_ADDR;
            end
        end
    end

    // Sticky status flags and the executed-instruction counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_r  <= 1'b0;
            load_err_r <= 1'b0;
            cycles_r   <= 8'd0;
        end else begin
            if ((xfer_s && fresh_s) || arm_req_s) begin
                timeout_r <= 1'b0;
            end else if (budget_hit_s) begin
                timeout_r <= 1'b1;
            end

            if (xfer_s && fresh_s) begin
                load_err_r <= 1'b0;
            end else if (xfer_s && !space_s) begin
                load_err_r <= 1'b1;
            end

            if (state_r == ST_ARM) begin
                cycles_r <= 8'd0;
            end else if (run_s) begin
                cycles_r <= cycles_r + 8'd1;
            end
        end
    end

    assign in_ready = in_ready_r;
    assign wr_en    = wr_en_r;
    assign WR_ADDR  = wr_addr_r;
    assign WR_DATA  = wr_data_r;
    assign set_pc   = set_pc_r;
    assign PC_INIT  = pc_init_r;
    assign run      = run_s;
    assign done     = done_r;
    assign timeout  = timeout_r;
    assign load_err = load_err_r;
    assign CYCLES   = cycles_r;

endmodule
